vote_tally: RTL and testbench
=============================

# vote_tally

Per-sample majority-vote aggregator for the random-forest datapath. It collects one class prediction per tree over a valid/ready handshake and picks the winning class once the configured number of trees has voted. It then emits one packed result word per sample on the same valid/value interface that the vote buffer consumes (`i_res_vld` / `i_res_val`). It sits directly upstream of the vote buffer, between the tree-evaluation engines and the PS-readable result BRAM.

## Interface
Parameters:
- `CLS_BIT`, 4 — class index width; `NCLS = 2**CLS_BIT` classes.
- `CNT_BIT`, 8 — vote counter width; at most `2**CNT_BIT-1` trees.
- `RES_WIDTH`, 16 — result word width; must be ≥ `CLS_BIT+CNT_BIT`.

Ports:
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `i_tally_rst` in 1 — synchronous soft clear; same effect as reset.
- `i_num_tree` in `CNT_BIT` — trees per sample; sampled on the first accepted vote of a sample.
- `i_vote_vld` in 1 — vote valid.
- `i_vote_cls` in `CLS_BIT` — voted class.
- `o_vote_rdy` out 1 — vote ready.
- `o_res_vld` out 1 — one-cycle result pulse; drives the vote buffer's `i_res_vld`.
- `o_res_val` out `RES_WIDTH` — result word; drives the vote buffer's `i_res_val`.
- `o_busy` out 1 — high from the first accepted vote of a sample through its EMIT cycle.

## Operation
- FSM states: IDLE, ACCUM, SCAN, EMIT.
- **Vote acceptance:** a vote is accepted when `i_vote_vld & o_vote_rdy`.
- **`o_vote_rdy`:** high in IDLE and ACCUM, low in SCAN and EMIT.
  - Additionally forced low in IDLE when `i_num_tree==0`; a zero tree count never starts a sample.
- **IDLE → ACCUM:** on an accepted vote. In the same edge:
  - latch `i_num_tree` into `num_q`;
  - increment `cnt[i_vote_cls]`;
  - set the accepted-vote count `acc` to 1.
  - If `num_q==1`, go straight to SCAN instead.
- **ACCUM:**
  - Each accepted vote increments `cnt[cls]` and `acc`.
  - When the accepted vote makes `acc == num_q`, go to SCAN.
  - Changes to `i_num_tree` mid-sample are ignored.
- **SCAN:**
  - Index `idx` runs 0..`NCLS-1`, one class per cycle.
  - A running best pair (`best_cls`, `best_cnt`) starts at (0, 0).
  - It is replaced only when `cnt[idx] > best_cnt` (strict). Ties therefore resolve to the lowest class index.
  - After `idx==NCLS-1`, go to EMIT.
- **EMIT:**
  - `o_res_vld` = 1 for exactly one cycle.
  - Result word layout:
    - `o_res_val[CLS_BIT-1:0]` = `best_cls`;
    - `o_res_val[CLS_BIT+CNT_BIT-1:CLS_BIT]` = `best_cnt`;
    - remaining upper bits = 0.
  - All `cnt[]`, `acc`, `best` are cleared; next state IDLE.
- **Overflow:** none is possible. Per-class counts never exceed `num_q ≤ 2**CNT_BIT-1`, so no saturation logic is needed.
- **Reset / soft clear:** `rst_n==0` or `i_tally_rst==1` clears counters, best pair and `num_q`, and forces IDLE.
  - Any partial sample is discarded; no `o_res_vld` is produced for it.
  - Clear has priority over a simultaneous vote, which is dropped.
- **Reset values of outputs:**
  - `o_vote_rdy` = 1 (if `i_num_tree != 0`);
  - `o_res_vld` = 0;
  - `o_res_val` = 0;
  - `o_busy` = 0.
- **`o_res_val` hold:** holds the last result until the next EMIT or a clear.

## Timing
- Last vote of a sample accepted on the edge ending cycle T.
- SCAN occupies cycles T+1 .. T+`NCLS`.
- `o_res_vld` is high in cycle T+`NCLS`+1.
- `o_vote_rdy` is high again in cycle T+`NCLS`+2.
- Throughput: one sample per `num_q + NCLS + 1` cycles when votes arrive back-to-back.
- All outputs are registered; there is no combinational path from inputs to `o_res_*`.
- `o_vote_rdy` depends combinationally only on state and `i_num_tree`.

## Configuration
- Macro: `VOTE_TALLY_SIM_EN`.
- **Defined:** adds simulation ports:
  - `o_state_sim` (2 bits);
  - `o_scan_idx_sim` (`CLS_BIT` bits);
  - `o_acc_sim` (`CNT_BIT` bits).
  These mirror the internal FSM state, the scan index and the accepted-vote count.
- **Not defined:** those ports and their logic are absent. Functional behaviour is identical either way.

## Structure
- Package `rf_vote_pkg`:
  - FSM state enum typedef `vote_tally_state_t`;
  - result-field offset localparams (`RES_CLS_LSB`, `RES_CNT_LSB`).
- Sub-module `vote_cnt_bank`:
  - `NCLS` × `CNT_BIT` counter array;
  - increment port (`inc`, `cls`), synchronous clear, read port (`rd_idx`, `rd_cnt`).
- The accepted-vote counter reuses the existing `counter_with_lat` (`inc`, `clear`).

## Test plan
Defaults (`CLS_BIT`=4, `CNT_BIT`=8, `RES_WIDTH`=16) unless noted.
- **Basic majority:** `i_num_tree`=5; back-to-back votes 3,3,1,3,7 → one `o_res_vld` pulse 17 cycles after the last vote, `o_res_val`=0x0033.
- **Tie:** `i_num_tree`=4; votes 5,2,5,2 → `o_res_val`=0x0022 (lower class wins).
- **Backpressure:** `i_vote_vld` held high continuously with `i_num_tree`=2 → `o_vote_rdy` low for cycles T+1..T+17; no vote is lost or double-counted; exactly one result per 19 cycles.
- **Soft clear mid-sample:** `i_num_tree`=5; 3 votes of class 4, then `i_tally_rst` pulse; then `i_num_tree`=1 with one vote of class 9 → only one result, `o_res_val`=0x0019.
- **Zero trees:** `i_num_tree`=0 with `i_vote_vld`=1 → `o_vote_rdy`=0, `o_busy`=0, no `o_res_vld` ever.
- **Reset with a vote present:** `rst_n` low for 2 cycles while `i_vote_vld`=1 → all outputs at reset values and counters zero; the following sample produces a correct result.

Source files
------------

// File: rtl/rf_vote_pkg.sv
// rf_vote_pkg: shared FSM state type and result-word field offsets for the vote tally
package rf_vote_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_EMIT} vote_tally_state_t;
  localparam int RES_CLS_LSB = 0;
  localparam int RES_CNT_LSB = RES_CLS_LSB + 4;
endpackage

// File: rtl/counter_with_lat.sv
// counter_with_lat: up-counter with synchronous clear taking priority over increment
module counter_with_lat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  // count accepted events, clear wins
  always_ff @(posedge clk) cnt_q <= clear ? '0 : cnt_q + W'(inc);
  assign cnt = cnt_q;
endmodule

// File: rtl/vote_cnt_bank.sv
// vote_cnt_bank: per-class vote counters with increment, synchronous clear and one read port
module vote_cnt_bank #(
  parameter int CLS_BIT = 4,
  parameter int CNT_BIT = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               inc,
  input  logic [CLS_BIT-1:0] cls,
  input  logic [CLS_BIT-1:0] rd_idx,
  output logic [CNT_BIT-1:0] rd_cnt
);
  localparam int NCLS = 2**CLS_BIT;
  logic [CNT_BIT-1:0] cnt_q [NCLS];
  // clear all counters or bump the voted class
  always_ff @(posedge clk)
    if (clear) for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
    else if (inc) cnt_q[cls] <= cnt_q[cls] + 1'b1;
  assign rd_cnt = cnt_q[rd_idx];
endmodule

// File: rtl/vote_tally.sv
// vote_tally: per-sample majority vote over num_tree class votes; VOTE_TALLY_SIM_EN adds debug mirror ports
module vote_tally
  import rf_vote_pkg::*;
#(
  parameter int CLS_BIT   = 4,
  parameter int CNT_BIT   = 8,
  parameter int RES_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tally_rst,
  input  logic [CNT_BIT-1:0]   i_num_tree,
  input  logic                 i_vote_vld,
  input  logic [CLS_BIT-1:0]   i_vote_cls,
  output logic                 o_vote_rdy,
  output logic                 o_res_vld,
  output logic [RES_WIDTH-1:0] o_res_val,
`ifdef VOTE_TALLY_SIM_EN
  output logic [1:0]           o_state_sim,
  output logic [CLS_BIT-1:0]   o_scan_idx_sim,
  output logic [CNT_BIT-1:0]   o_acc_sim,
`endif
  output logic                 o_busy
);
  localparam int NCLS = 2**CLS_BIT;
  vote_tally_state_t state_q, state_d;
  logic [CNT_BIT-1:0] num_q, num_d, acc, rd_cnt, best_cnt_q, best_cnt_d;
  logic [CLS_BIT-1:0] idx_q, idx_d, best_cls_q, best_cls_d;
  logic [RES_WIDTH-1:0] res_q, res_d;
  logic clr, accept, emit;
  assign clr = ~rst_n | i_tally_rst;
  assign o_vote_rdy = (state_q == S_ACCUM) | ((state_q == S_IDLE) & (i_num_tree != '0));
  assign accept = i_vote_vld & o_vote_rdy & ~clr;
  assign emit = state_q == S_EMIT;
  counter_with_lat #(.W(CNT_BIT)) u_acc (
    .clk   (clk),
    .inc   (accept),
    .clear (clr | emit),
    .cnt   (acc)
  );
  vote_cnt_bank #(.CLS_BIT(CLS_BIT), .CNT_BIT(CNT_BIT)) u_bank (
    .clk    (clk),
    .clear  (clr | emit),
    .inc    (accept),
    .cls    (i_vote_cls),
    .rd_idx (idx_q),
    .rd_cnt (rd_cnt)
  );
  // next state, running best pair, and result word captured on the final scan step
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    idx_d = idx_q;
    best_cls_d = best_cls_q;
    best_cnt_d = best_cnt_q;
    res_d = res_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        num_d = i_num_tree;
        state_d = (i_num_tree == CNT_BIT'(1)) ? S_SCAN : S_ACCUM;
      end
      S_ACCUM: if (accept && (acc + 1'b1) == num_q) state_d = S_SCAN;
      S_SCAN: begin
        best_cls_d = (rd_cnt > best_cnt_q) ? idx_q : best_cls_q;
        best_cnt_d = (rd_cnt > best_cnt_q) ? rd_cnt : best_cnt_q;
        idx_d = idx_q + 1'b1;
        if (idx_q == CLS_BIT'(NCLS - 1)) begin
          state_d = S_EMIT;
          res_d = '0;
          res_d[RES_CLS_LSB +: CLS_BIT] = best_cls_d;
          res_d[RES_CLS_LSB + CLS_BIT +: CNT_BIT] = best_cnt_d;
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
        idx_d = '0;
        best_cls_d = '0;
        best_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers; reset and soft clear discard any partial sample
  always_ff @(posedge clk)
    if (!rst_n || i_tally_rst) begin
      state_q <= S_IDLE;
      num_q <= '0;
      idx_q <= '0;
      best_cls_q <= '0;
      best_cnt_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      idx_q <= idx_d;
      best_cls_q <= best_cls_d;
      best_cnt_q <= best_cnt_d;
      res_q <= res_d;
    end
  assign o_res_vld = emit;
  assign o_res_val = res_q;
  assign o_busy = state_q != S_IDLE;
`ifdef VOTE_TALLY_SIM_EN
  assign o_state_sim = state_q;
  assign o_scan_idx_sim = idx_q;
  assign o_acc_sim = acc;
`endif
endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed checks of majority, tie, backpressure, soft clear, zero trees and reset
module tb_vote_tally;
  logic clk = 0, rst_n, i_tally_rst, i_vote_vld, o_vote_rdy, o_res_vld, o_busy;
  logic [7:0] i_num_tree;
  logic [3:0] i_vote_cls;
  logic [15:0] o_res_val;
  int ncmp = 0, nerr = 0, nres = 0;

  vote_tally dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tally_rst (i_tally_rst),
    .i_num_tree  (i_num_tree),
    .i_vote_vld  (i_vote_vld),
    .i_vote_cls  (i_vote_cls),
    .o_vote_rdy  (o_vote_rdy),
    .o_res_vld   (o_res_vld),
    .o_res_val   (o_res_val),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (o_res_vld) nres <= nres + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] c);
    i_vote_vld = 1;
    i_vote_cls = c;
    tick;
  endtask

  // called in cycle T+1 after the last vote; checks the pulse lands in T+17 only
  task automatic expect_res(input string tag, input logic [15:0] v);
    chk({tag, "_busy_scan"}, o_busy, 1);
    chk({tag, "_rdy_scan"}, o_vote_rdy, 0);
    repeat (15) tick;
    chk({tag, "_vld_early"}, o_res_vld, 0);
    tick;
    chk({tag, "_vld"}, o_res_vld, 1);
    chk({tag, "_val"}, o_res_val, 32'(v));
    tick;
    chk({tag, "_vld_once"}, o_res_vld, 0);
    chk({tag, "_rdy_back"}, o_vote_rdy, 1);
    chk({tag, "_hold"}, o_res_val, 32'(v));
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    rst_n = 0; i_tally_rst = 0; i_vote_vld = 1; i_vote_cls = 6; i_num_tree = 3;
    tick;
    chk("rst_vld", o_res_vld, 0);
    chk("rst_val", o_res_val, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rdy", o_vote_rdy, 1);
    tick;
    rst_n = 1; i_vote_vld = 0;
    tick;
    chk("post_rst_busy", o_busy, 0);

    i_num_tree = 5;
    send(3); send(3); send(1); send(3); send(7);
    i_vote_vld = 0;
    expect_res("basic", 16'h0033);
    chk("basic_count", nres, 1);

    i_num_tree = 4;
    send(5); send(2); send(5); send(2);
    i_vote_vld = 0;
    expect_res("tie", 16'h0022);

    i_num_tree = 2;
    i_vote_vld = 1; i_vote_cls = 7;
    tick;
    chk("bp_accum_busy", o_busy, 1);
    chk("bp_accum_rdy", o_vote_rdy, 1);
    tick;
    chk("bp_rdy_t1", o_vote_rdy, 0);
    repeat (16) tick;
    chk("bp_rdy_t17", o_vote_rdy, 0);
    chk("bp_vld1", o_res_vld, 1);
    chk("bp_val1", o_res_val, 16'h0027);
    i_vote_cls = 8;
    tick;
    chk("bp_rdy_t18", o_vote_rdy, 1);
    chk("bp_vld_once", o_res_vld, 0);
    tick;
    chk("bp_rdy_t19", o_vote_rdy, 1);
    chk("bp_busy_t19", o_busy, 1);
    tick;
    chk("bp_rdy_t20", o_vote_rdy, 0);
    repeat (15) tick;
    chk("bp_vld2_early", o_res_vld, 0);
    tick;
    chk("bp_vld2", o_res_vld, 1);
    chk("bp_val2", o_res_val, 16'h0028);
    i_vote_vld = 0;
    tick;
    chk("bp_count", nres, 4);

    i_num_tree = 5;
    send(4); send(4); send(4);
    i_vote_vld = 0; i_tally_rst = 1;
    tick;
    i_tally_rst = 0;
    chk("clr_busy", o_busy, 0);
    chk("clr_val", o_res_val, 0);
    chk("clr_rdy", o_vote_rdy, 1);
    repeat (20) tick;
    chk("clr_no_res", nres, 4);
    i_num_tree = 1;
    send(9);
    i_vote_vld = 0;
    expect_res("clr", 16'h0019);
    chk("clr_count", nres, 5);

    i_num_tree = 0; i_vote_vld = 1; i_vote_cls = 2;
    tick;
    chk("zero_rdy", o_vote_rdy, 0);
    chk("zero_busy", o_busy, 0);
    repeat (20) tick;
    chk("zero_busy_late", o_busy, 0);
    chk("zero_count", nres, 5);
    i_vote_vld = 0;

    i_num_tree = 3;
    send(6); send(6);
    rst_n = 0; i_vote_cls = 6;
    tick;
    chk("rst2_vld", o_res_vld, 0);
    chk("rst2_val", o_res_val, 0);
    chk("rst2_busy", o_busy, 0);
    chk("rst2_rdy", o_vote_rdy, 1);
    tick;
    rst_n = 1; i_vote_vld = 0;
    tick;
    send(1); send(1); send(6);
    i_vote_vld = 0;
    expect_res("rst2", 16'h0021);
    chk("rst2_count", nres, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
